serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor: computes `diff = a - b - borrow_in` over `NUM_BITS` inputs, resolving one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's combinational ripple adder. It sits in the same datapath library, and its results are checked against a reference `a - b - borrow_in` exactly as the adder is checked against `a + b + carry_in`. The operation is started by a one-cycle request, and completion is signalled by a one-cycle `done` pulse.

## Interface
- `NUM_BITS`, default 4: operand and difference width; legal range ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  `NUM_BITS`  minuend; captured on the accepting edge.
- `b`  in  `NUM_BITS`  subtrahend; captured on the accepting edge.
- `borrow_in`  in  1  initial borrow; captured on the accepting edge.
- `busy`  out  1  high while in SHIFT or DONE.
- `done`  out  1  one-cycle completion pulse.
- `diff`  out  `NUM_BITS`  last completed difference; held between operations.
- `underflow`  out  1  final borrow out of the MSB, i.e. unsigned `a < b + borrow_in`.
- `overflow_s`  out  1  signed overflow; present only with `SERIAL_SUB_SIGNED_OVF_EN`.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE → SHIFT:** on an edge with `start`=1.
  - Latch `a` and `b` into shift registers.
  - Load the borrow FF with `borrow_in`.
  - Clear the bit counter to 0.
- **SHIFT:** each edge performs one bit step.
  - `d = a0 ^ b0 ^ br`.
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - `d` shifts into the MSB of the result shift register; the operand registers shift right by 1.
  - The counter increments.
- **SHIFT → DONE:** on the edge where counter = `NUM_BITS`-1 (the last bit step).
  - On that same edge, the `diff` output register loads the full result.
  - `underflow` loads `br_next`.
- **DONE → IDLE:** unconditionally on the next edge.
- **`start` handling:**
  - `start` in SHIFT or DONE is ignored; it is not queued.
  - `start` held high continuously yields back-to-back operations every `NUM_BITS`+2 cycles.
- **Output stability:** `diff` and `underflow` change only on the completion edge. Intermediate shift-register contents are never visible.
- **Arithmetic:** modulo 2^`NUM_BITS`. `{underflow, diff}` equals the (`NUM_BITS`+1)-bit two's-complement result of `a - b - borrow_in`.
- **Input changes:** inputs changing during SHIFT have no effect.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `diff`=0, `underflow`=0 (`overflow_s`=0 when present).
  - FSM = IDLE; internal registers = 0.
- **Reset mid-operation:** asserting `n_rst` in SHIFT or DONE immediately aborts the operation.
  - Outputs return to their reset values.
  - No `done` is produced for the aborted operation.
- **Latency:** accepting edge E0.
  - `busy` goes high after E0.
  - Bit steps occur on E1…E`NUM_BITS`.
  - `done`=1 and the new `diff` are valid in the cycle following E`NUM_BITS`.
  - `busy` drops after E`NUM_BITS`+1.
- **Flag registration:** `done` and `busy` are registered outputs decoded from state (`done` = state==DONE). They are glitch-free.
- **Minimum restart:** `start` is next accepted on edge E`NUM_BITS`+2.

## Configuration
- **`SERIAL_SUB_SIGNED_OVF_EN` defined:**
  - Adds output `overflow_s`, loaded on the completion edge as `br_next ^ br` from the final (MSB) step, which is signed overflow of `a - b - borrow_in`.
  - It holds and resets like `underflow`.
- **Not defined:** the port and its logic are absent; all other behaviour is identical.

## Test plan
- **Basic subtraction:** reset, `NUM_BITS`=4; start `a`=9, `b`=5, `borrow_in`=0 → `done` pulse exactly 4 cycles after the accepting edge; `diff`=4, `underflow`=0.
- **Unsigned underflow:** `a`=3, `b`=5, `borrow_in`=0 → `diff`=14, `underflow`=1. Then `a`=0, `b`=0, `borrow_in`=1 → `diff`=15, `underflow`=1.
- **Signed overflow (macro defined):** `a`=8, `b`=1, `borrow_in`=0 → `diff`=7, `underflow`=0, `overflow_s`=1. `a`=7, `b`=1 → `overflow_s`=0.
- **Ignored start / stable outputs:** pulse `start` with new operands two cycles into SHIFT.
  - Only one `done` is produced, with the first result.
  - `diff` holds its previous value until the completion edge.
  - `start` held high → `done` every 6 cycles.
- **Reset mid-operation:** drop `n_rst` mid-SHIFT → `busy`, `done`, `diff` and `underflow` are 0 immediately; no `done` follows release; the next operation is correct.
- **Exhaustive:** loop all 512 combinations of {`borrow_in`, `b`, `a`}. Per case, compare `{underflow, diff}` against `a - b - borrow_in` (5-bit), with `$error` on mismatch. The final block reports whether all cases ran.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                underflow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic                overflow_s
`endif
);

    localparam int CW = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] res_q, res_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                br_q, br_d;
    logic                unf_q, unf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_d;
    logic                br_nx;
    logic                last;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    // Single full-subtractor cell on the operand LSBs.
    assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last  = (cnt_q == CW'(NUM_BITS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            unf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            unf_q   <= unf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        unf_d   = unf_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bit_d, res_q[NUM_BITS-1:1]};
                br_d  = br_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    diff_d  = {bit_d, res_q[NUM_BITS-1:1]};
                    unf_d   = br_nx;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // Borrow into vs. out of the MSB disagree on overflow.
                    ovf_d   = br_nx ^ br_q;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags are registered from the next state so they never glitch.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign underflow = unf_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign overflow_s = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         underflow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         overflow_s;
`endif

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_diff;
    logic         exp_unf;
    logic         exp_ovf;

    serial_subtractor #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .underflow (underflow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .overflow_s(overflow_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain (N+1)-bit wrap of a - b - borrow_in.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic bi);
        int r;
        r = int'(x) - int'(y) - int'(bi);
        return (N + 1)'(r);
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] x,
                                     input logic [N-1:0] y,
                                     input logic bi);
        int sx, sy, r;
        sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
        sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
        r  = sx - sy - int'(bi);
        return (r < -(1 << (N - 1))) || (r > (1 << (N - 1)) - 1);
    endfunction

    task automatic check_outs(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, 32'(overflow_s), 32'(exp_ovf));
`endif
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic tbi, input bit noisy);
        logic [N:0] r;
        int lat;
        r   = ref_sub(ta, tb_v, tbi);
        lat = -1;
        a = ta;
        b = tb_v;
        borrow_in = tbi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
        for (int k = 1; k <= N + 3; k++) begin
            if (noisy) begin
                a = N'($urandom);
                b = N'($urandom);
                borrow_in = 1'($urandom);
                start = (k == 2);
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            check("diff_hold", 32'(diff), 32'(exp_diff));
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(N));
        exp_diff = r[N-1:0];
        exp_unf  = r[N];
        exp_ovf  = ref_ovf(ta, tb_v, tbi);
        check_outs("op");
        @(posedge clk);
        #1;
        check("done_off", 32'(done), 32'd0);
        check("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        int cyc;
        int prev;
        n_rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        borrow_in = 1'b0;
        exp_diff = '0;
        exp_unf = 1'b0;
        exp_ovf = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_outs("rst");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(4'd9, 4'd5, 1'b0, 1'b0);
        run_op(4'd3, 4'd5, 1'b0, 1'b0);
        run_op(4'd0, 4'd0, 1'b1, 1'b0);
        run_op(4'd8, 4'd1, 1'b0, 1'b0);
        run_op(4'd7, 4'd1, 1'b0, 1'b0);
        run_op(4'd15, 4'd15, 1'b1, 1'b1);

        // Start held high: a fresh operation every N+2 cycles.
        a = 4'd6;
        b = 4'd2;
        borrow_in = 1'b1;
        start = 1'b1;
        dn = 0;
        prev = 0;
        for (cyc = 1; cyc <= 3 * (N + 2); cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (dn == 0)
                    check("b2b_first", 32'(cyc), 32'(N + 1));
                else
                    check("b2b_gap", 32'(cyc - prev), 32'(N + 2));
                check("b2b_diff", 32'(diff), 32'd3);
                prev = cyc;
                dn++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(dn), 32'd3);
        for (int k = 0; k < N + 3 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_idle", 32'(busy), 32'd0);
        exp_diff = 4'd3;
        exp_unf = 1'b0;
        exp_ovf = 1'b0;

        // Reset in the middle of SHIFT.
        a = 4'd12;
        b = 4'd1;
        borrow_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        exp_diff = '0;
        exp_unf = 1'b0;
        exp_ovf = 1'b0;
        check_outs("mid");
        @(negedge clk);
        n_rst = 1'b1;
        dn = 0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("mid_nodone", 32'(dn), 32'd0);
        run_op(4'd10, 4'd3, 1'b1, 1'b0);

        // Every {borrow_in, b, a} combination.
        dn = 0;
        for (int i = 0; i < 512; i++) begin
            run_op(N'(i), N'(i >> 4), 1'(i >> 8), 1'b0);
            dn++;
        end
        check("exh_count", 32'(dn), 32'd512);

        // Random operands with input noise and stray starts during SHIFT.
        for (int i = 0; i < 200; i++)
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
